// File: rtl/bus_tx_if.sv
// Handshake and wire-side signals between the frame source, bus_tx_ctrl
// and the tristate buffer stage.
interface bus_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              bus_in;
   logic              bus_out;
   logic              bus_en;
   logic              busy;
   logic              done;
   logic              ack;

   modport master (
      input  tx_data, tx_valid, bus_in,
      output tx_ready, bus_out, bus_en, busy, done, ack
   );

   modport slave (
      output tx_data, tx_valid, bus_in,
      input  tx_ready, bus_out, bus_en, busy, done, ack
   );
endinterface

// File: rtl/bus_tx_ctrl.sv
// Single-wire half-duplex transmitter: start bit, MSB-first data, stop bit,
// wire release for turnaround, then an active-low acknowledge sample.
module bus_tx_ctrl #(
   parameter int DATA_W      = 8,
   parameter int BIT_CYCLES  = 4,
   parameter int TURN_CYCLES = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   bus_tx_if.master  bus
);
   localparam int CNT_MAX = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_TOP   = BIT_W'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_TURN, S_ACKW, S_DONE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [BIT_W-1:0]  bit_idx;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] sh_next;
   logic              bus_en_r, bus_out_r, tx_ready_r, busy_r, done_r, ack_r;

   assign sh_next = shreg << 1;

   // Every output is a flop with async reset, so reset drops bus_en at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         bus_en_r   <= 1'b0;
         bus_out_r  <= 1'b1;
         tx_ready_r <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ack_r      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.tx_valid) begin
                  shreg      <= bus.tx_data;
                  state      <= S_START;
                  cnt        <= BIT_LAST;
                  bus_en_r   <= 1'b1;
                  bus_out_r  <= 1'b0;
                  tx_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            S_START: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               else begin
                  state     <= S_DATA;
                  cnt       <= BIT_LAST;
                  bit_idx   <= BIT_TOP;
                  bus_out_r <= shreg[DATA_W-1];
               end
            end
            S_DATA: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               else if (bit_idx != '0) begin
                  // bus_out follows the bit that becomes MSB after this shift
                  shreg     <= sh_next;
                  bus_out_r <= sh_next[DATA_W-1];
                  bit_idx   <= bit_idx - BIT_W'(1);
                  cnt       <= BIT_LAST;
               end else begin
                  state     <= S_STOP;
                  cnt       <= BIT_LAST;
                  bus_out_r <= 1'b1;
               end
            end
            S_STOP: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               else begin
                  state    <= S_TURN;
                  cnt      <= TURN_LAST;
                  bus_en_r <= 1'b0;
               end
            end
            S_TURN: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               else begin
                  state <= S_ACKW;
                  cnt   <= BIT_LAST;
               end
            end
            S_ACKW: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
               else begin
                  state  <= S_DONE;
                  ack_r  <= ~bus.bus_in;
                  done_r <= 1'b1;
               end
            end
            S_DONE: begin
               state      <= S_IDLE;
               done_r     <= 1'b0;
               tx_ready_r <= 1'b1;
               busy_r     <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.bus_en   = bus_en_r;
   assign bus.bus_out  = bus_out_r;
   assign bus.tx_ready = tx_ready_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.ack      = ack_r;
endmodule

// File: tb/tb_bus_tx_ctrl.sv
// Bench for bus_tx_ctrl: frame-level reference model plus directed frames
// with literal wire patterns and timing points.
module tb_bus_tx_ctrl;
   localparam int DW = 8;
   localparam int BC = 4;
   localparam int TC = 2;
   localparam int L  = (DW + 3) * BC + TC + 1;  // done cycle, 47

   logic clk, rst_n;
   int   checks = 0;
   int   errors = 0;

   bus_tx_if #(.DATA_W(DW)) bif ();

   bus_tx_ctrl #(.DATA_W(DW), .BIT_CYCLES(BC), .TURN_CYCLES(TC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Reference model: a frame is just a phase count since the handshake.
   logic          m_act;
   int            m_ph;
   logic [DW-1:0] m_word;
   logic          m_ack;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act <= 1'b0;
         m_ph  <= 0;
         m_ack <= 1'b0;
      end else if (!m_act) begin
         if (bif.tx_valid) begin
            m_act  <= 1'b1;
            m_ph   <= 1;
            m_word <= bif.tx_data;
         end
      end else begin
         if (m_ph == L - 1) m_ack <= ~bif.bus_in;
         if (m_ph == L) m_act <= 1'b0;
         else m_ph <= m_ph + 1;
      end
   end

   function automatic logic wire_level(input int p, input logic [DW-1:0] w);
      if (p <= BC) return 1'b0;
      if (p <= (DW + 1) * BC) return w[DW - 1 - (p - BC - 1) / BC];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      chk("m_bus_en", bif.bus_en, m_act && m_ph <= (DW + 2) * BC);
      chk("m_busy", bif.busy, m_act);
      chk("m_tx_ready", bif.tx_ready, !m_act);
      chk("m_done", bif.done, m_act && m_ph == L);
      chk("m_ack", bif.ack, m_ack);
      if (!m_act)
         chk("m_bus_out_idle", bif.bus_out, 1'b1);
      else if (m_ph <= (DW + 2) * BC + TC)
         chk("m_bus_out", bif.bus_out, wire_level(m_ph, m_word));
   end

   // One frame, called on a negedge; handshake lands on the next edge.
   // pat lists the ten wire levels, first level in bit 9.
   task automatic frame(input logic [DW-1:0] w, input logic [9:0] pat,
                        input logic ack_bit, input bit inject, input bit keep,
                        input logic [DW-1:0] next_w, input bit rnd);
      bif.tx_valid = 1'b1;
      bif.tx_data  = w;
      for (int n = 1; n <= L + 1; n++) begin
         @(negedge clk);
         if (n == 1) begin
            bif.tx_valid = 1'b0;
            chk("lit_busy_c1", bif.busy, 1'b1);
            chk("lit_ready_c1", bif.tx_ready, 1'b0);
         end
         if (inject && n == 10) begin
            bif.tx_valid = 1'b1;
            bif.tx_data  = 8'hFF;
         end
         if (inject && n == 12) bif.tx_valid = 1'b0;
         if (keep && n == 44) begin
            bif.tx_valid = 1'b1;
            bif.tx_data  = next_w;
         end
         if (n <= 40) begin
            chk("lit_en_drive", bif.bus_en, 1'b1);
            chk("lit_wire", bif.bus_out, pat[9 - (n - 1) / 4]);
         end else if (n <= L) begin
            chk("lit_en_release", bif.bus_en, 1'b0);
         end
         if (rnd) begin
            if (n >= 41 && n <= 44) bif.bus_in = 1'($urandom);
            if (n == 45) bif.bus_in = ~ack_bit;
            if (n == 46) bif.bus_in = ack_bit;
         end else if (n == 43) bif.bus_in = ack_bit;
         if (n == 47) bif.bus_in = 1'b1;
         if (n == 46) chk("lit_done_early", bif.done, 1'b0);
         if (n == L) begin
            chk("lit_done", bif.done, 1'b1);
            chk("lit_ack", bif.ack, ~ack_bit);
         end
         if (n == L + 1) begin
            chk("lit_ready_back", bif.tx_ready, 1'b1);
            chk("lit_done_off", bif.done, 1'b0);
            chk("lit_ack_hold", bif.ack, ~ack_bit);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n        = 1'b0;
      bif.tx_valid = 1'b1;
      bif.tx_data  = 8'h77;
      bif.bus_in   = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_en", bif.bus_en, 1'b0);
      chk("rst_out", bif.bus_out, 1'b1);
      chk("rst_ready", bif.tx_ready, 1'b1);
      chk("rst_busy", bif.busy, 1'b0);
      chk("rst_done", bif.done, 1'b0);
      chk("rst_ack", bif.ack, 1'b0);
      bif.tx_valid = 1'b0;
      rst_n        = 1'b1;
      repeat (2) @(negedge clk);

      // 0xA5 acknowledged, 0x3C unacknowledged
      frame(8'hA5, 10'b0101001011, 1'b0, 0, 0, 8'h00, 0);
      repeat (3) @(negedge clk);
      frame(8'h3C, 10'b0001111001, 1'b1, 0, 0, 8'h00, 0);
      repeat (3) @(negedge clk);

      // busy rejection, then back-to-back with noisy turnaround
      frame(8'hA5, 10'b0101001011, 1'b0, 1, 1, 8'h3C, 0);
      frame(8'h3C, 10'b0001111001, 1'b0, 0, 0, 8'h00, 1);
      repeat (3) @(negedge clk);
      chk("idle_after_b2b", bif.tx_ready, 1'b1);

      // reset during DATA bit 3 (cycles 17..20), between edges
      bif.tx_valid = 1'b1;
      bif.tx_data  = 8'hA5;
      @(negedge clk);
      bif.tx_valid = 1'b0;
      repeat (17) @(negedge clk);
      chk("pre_rst_en", bif.bus_en, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_en", bif.bus_en, 1'b0);
      chk("async_ack", bif.ack, 1'b0);
      chk("async_busy", bif.busy, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("post_rst_ready", bif.tx_ready, 1'b1);
      chk("post_rst_ack", bif.ack, 1'b0);

      // random bus_in before the sample point, far end silent at the end
      frame(8'h3C, 10'b0001111001, 1'b1, 0, 0, 8'h00, 1);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
